// File: rtl/data_memory_ctrl_if.sv
// data_memory_ctrl_if: request/response bus between a requester and the data memory controller.
//   req_valid / req_ready : request handshake (transfer on a rising edge with both high)
//   req_we                : 1 = store, 0 = load
//   req_size              : 0 byte, 1 half, 2 word, 3 double
//   req_unsigned          : load zero-extends when 1, sign-extends when 0
//   req_addr / req_wdata  : byte address and right-aligned store data
//   rsp_valid             : one-cycle response pulse
//   rsp_rdata / rsp_err   : extended load data and access fault
interface data_memory_ctrl_if #(
    parameter int unsigned XLEN = 64
);
    logic            req_valid;
    logic            req_ready;
    logic            req_we;
    logic [1:0]      req_size;
    logic            req_unsigned;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] req_wdata;
    logic            rsp_valid;
    logic [XLEN-1:0] rsp_rdata;
    logic            rsp_err;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/data_memory_ctrl.sv
// data_memory_ctrl: byte-addressed little-endian data memory with a single outstanding access.
// An access is captured on acceptance, then performed in one beat (within one word) or two
// beats (straddling a word boundary), and answered with a one-cycle response pulse.
//   clk   : clock, all state updates on the rising edge
//   rst_n : asynchronous active-low reset (memory contents are not reset)
//   bus   : data_memory_ctrl_if.slave, request handshake/fields and response
module data_memory_ctrl #(
    parameter int unsigned XLEN        = 64,
    parameter int unsigned DEPTH_WORDS = 512
) (
    input  logic              clk,
    input  logic              rst_n,
    data_memory_ctrl_if.slave bus
);
    localparam int unsigned BYTES     = XLEN / 8;
    localparam int unsigned MEM_BYTES = DEPTH_WORDS * BYTES;
    localparam int unsigned OFFW      = $clog2(BYTES);
    localparam int unsigned IDXW      = $clog2(DEPTH_WORDS);
    localparam int unsigned LW        = XLEN + 1;

    typedef enum logic [1:0] {StIdle, StBeat1, StBeat2, StResp} state_e;

    state_e state_q, state_d;

    // Captured request
    logic            we_q;
    logic            uns_q;
    logic            err_q;
    logic            split_q;
    logic [1:0]      size_q;
    logic [OFFW-1:0] off_q;
    logic [IDXW-1:0] idx_q;
    logic [XLEN-1:0] wdata_q;
    // Low word read in beat 1, needed to assemble a split load in beat 2
    logic [XLEN-1:0] lo_q;
    logic [XLEN-1:0] rdata_q, rdata_d;

    logic [XLEN-1:0] mem_q [DEPTH_WORDS];

    logic accept;
    assign accept = bus.req_valid & bus.req_ready;

    // ------------------------------------------------------------------
    // Request decode, evaluated on the incoming fields at acceptance
    // ------------------------------------------------------------------
    logic [3:0]    req_nbytes;
    logic [LW-1:0] req_last;
    logic          req_fault;
    logic          req_split;

    always_comb begin
        req_nbytes = 4'd1 << bus.req_size;
        // Last addressed byte computed one bit wider so high addresses cannot wrap into range.
        req_last   = {1'b0, bus.req_addr} + LW'(req_nbytes) - LW'(1);
        req_fault  = (req_last >= LW'(MEM_BYTES)) || ((XLEN == 32) && (bus.req_size == 2'd3));
        req_split  = !req_fault &&
                     ((5'(bus.req_addr[OFFW-1:0]) + 5'(req_nbytes)) > 5'(BYTES));
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = StBeat1;
            StBeat1: state_d = split_q ? StBeat2 : StResp;
            StBeat2: state_d = StResp;
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Beat datapath
    // ------------------------------------------------------------------
    logic               beat2;
    logic [IDXW-1:0]    widx;
    logic [XLEN-1:0]    rd_word;
    logic [3:0]         nbytes;
    logic [6:0]         nbits;
    logic [2*BYTES-1:0] be_wide;
    logic [2*XLEN-1:0]  wd_wide;
    logic [2*XLEN-1:0]  rd_wide;
    logic [BYTES-1:0]   be_cur;
    logic [XLEN-1:0]    wd_cur;
    logic [XLEN-1:0]    raw;
    logic [XLEN-1:0]    ext_mask;
    logic [XLEN-1:0]    sign_mask;
    logic               wr_en;
    logic               finish;

    always_comb begin
        beat2   = (state_q == StBeat2);
        widx    = beat2 ? idx_q + IDXW'(1) : idx_q;
        rd_word = mem_q[widx];
        nbytes  = 4'd1 << size_q;
        nbits   = 7'(nbytes) << 3;

        // Byte enables and data laid out across the two-word window starting at the low word;
        // the upper half belongs to beat 2. Store bytes beyond the access size fall outside the
        // enabled lanes, so they never reach memory.
        be_wide = ~({(2*BYTES){1'b1}} << nbytes) << off_q;
        wd_wide = {{XLEN{1'b0}}, wdata_q} << {off_q, 3'b000};
        be_cur  = beat2 ? be_wide[2*BYTES-1:BYTES] : be_wide[BYTES-1:0];
        wd_cur  = beat2 ? wd_wide[2*XLEN-1:XLEN]   : wd_wide[XLEN-1:0];
        wr_en   = we_q && !err_q && ((state_q == StBeat1) || beat2);

        // Load assembly: concatenate high/low words, align, then extend.
        rd_wide   = beat2 ? {rd_word, lo_q} : {{XLEN{1'b0}}, rd_word};
        raw       = XLEN'(rd_wide >> {off_q, 3'b000});
        ext_mask  = {XLEN{1'b1}} << nbits;
        sign_mask = XLEN'(1) << (nbits - 7'd1);
        raw       = raw & ~ext_mask;
        if (!uns_q && ((raw & sign_mask) != '0)) begin
            raw = raw | ext_mask;
        end

        // Last beat of the access: load result is latched here and held until the next one.
        finish  = ((state_q == StBeat1) && !split_q) || beat2;
        rdata_d = rdata_q;
        if (finish) begin
            rdata_d = (we_q || err_q) ? '0 : raw;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
            split_q <= 1'b0;
            size_q  <= 2'd0;
            off_q   <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            lo_q    <= '0;
            rdata_q <= '0;
        end else begin
            if (accept) begin
                we_q    <= bus.req_we;
                uns_q   <= bus.req_unsigned;
                err_q   <= req_fault;
                split_q <= req_split;
                size_q  <= bus.req_size;
                off_q   <= bus.req_addr[OFFW-1:0];
                idx_q   <= bus.req_addr[OFFW+IDXW-1:OFFW];
                wdata_q <= bus.req_wdata;
            end
            if (state_q == StBeat1) begin
                lo_q <= rd_word;
            end
            rdata_q <= rdata_d;
        end
    end

    // Storage has no reset; a reset forces the FSM to idle, which blocks any pending beat-2 write.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int unsigned b = 0; b < BYTES; b++) begin
                if (be_cur[b]) begin
                    mem_q[widx][8*b +: 8] <= wd_cur[8*b +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.req_ready = (state_q == StIdle);
    assign bus.rsp_valid = (state_q == StResp);
    assign bus.rsp_err   = (state_q == StResp) && err_q;
    assign bus.rsp_rdata = rdata_q;
endmodule

// File: tb/tb_data_memory_ctrl.sv
// tb_data_memory_ctrl: scoreboard bench for data_memory_ctrl (XLEN=64, DEPTH_WORDS=512).
// The driver pushes the expected response of every accepted request; a negedge monitor pops and
// compares on each rsp_valid pulse. Expectations come from a byte-array memory model.
module tb_data_memory_ctrl;
    localparam int unsigned XLEN        = 64;
    localparam int unsigned DEPTH_WORDS = 512;
    localparam int unsigned MEM_BYTES   = DEPTH_WORDS * 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    data_memory_ctrl_if #(.XLEN(XLEN)) bus ();

    data_memory_ctrl #(
        .XLEN        (XLEN),
        .DEPTH_WORDS (DEPTH_WORDS)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [63:0]     rdata;
        logic            err;
        int unsigned     lat;
        longint unsigned acc;
        logic            we;
        logic [1:0]      size;
        logic [63:0]     addr;
    } exp_t;

    exp_t            exp_q[$];
    byte unsigned    ref_mem [MEM_BYTES];
    int              checks   = 0;
    int              failures = 0;
    longint unsigned cyc      = 0;
    logic [63:0]     last_rdata;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%h required 0x%h", name, act, req);
        end
    endtask

    // Reference model: byte-level memory, fault/split rules from address arithmetic.
    function automatic exp_t model(input logic we, input logic [1:0] size, input logic uns,
                                   input logic [63:0] addr, input logic [63:0] wdata);
        exp_t        e;
        int unsigned n;
        int unsigned base;
        logic [64:0] end_excl;
        logic [63:0] val;
        n        = 1 << size;
        end_excl = {1'b0, addr} + 65'(n);
        e.err    = (end_excl > 65'(MEM_BYTES));
        e.lat    = (!e.err && ((addr % 8) + 64'(n) > 64'd8)) ? 3 : 2;
        val      = '0;
        if (!e.err) begin
            base = int'(addr[12:0]);
            if (we) begin
                for (int unsigned i = 0; i < n; i++) ref_mem[base + i] = wdata[8*i +: 8];
            end else begin
                for (int unsigned i = 0; i < n; i++) val[8*i +: 8] = ref_mem[base + i];
                if (!uns && val[8*n-1]) begin
                    for (int unsigned i = n; i < 8; i++) val[8*i +: 8] = 8'hFF;
                end
            end
        end
        e.rdata = val;
        e.acc   = 0;
        e.we    = we;
        e.size  = size;
        e.addr  = addr;
        return e;
    endfunction

    // Present a request and leave req_valid high; a following issue() makes it back-to-back.
    task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                         input logic [63:0] addr, input logic [63:0] wdata,
                         input logic use_lit = 1'b0, input logic [63:0] lit = '0);
        int   waited;
        exp_t e;
        waited = 0;
        @(negedge clk);
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        while (!bus.req_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.req_ready) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: req_ready=0 after 20 cycles, required 1");
            bus.req_valid = 1'b0;
        end else begin
            e = model(we, size, uns, addr, wdata);
            if (use_lit) e.rdata = lit;
            e.acc = cyc;
            exp_q.push_back(e);
            @(posedge clk);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: %0d responses outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Monitor
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            last_rdata = '0;
        end else if (bus.rsp_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_rsp: got rsp_valid=1 with nothing outstanding");
            end else begin
                e = exp_q.pop_front();
                check($sformatf("rdata we=%0d size=%0d addr=%h", e.we, e.size, e.addr),
                      bus.rsp_rdata, e.rdata);
                check($sformatf("err we=%0d size=%0d addr=%h", e.we, e.size, e.addr),
                      64'(bus.rsp_err), 64'(e.err));
                check($sformatf("latency we=%0d size=%0d addr=%h", e.we, e.size, e.addr),
                      cyc - e.acc, 64'(e.lat));
                check("ready_low_in_rsp", 64'(bus.req_ready), 64'd0);
            end
            last_rdata = bus.rsp_rdata;
        end else begin
            check("rdata_hold", bus.rsp_rdata, last_rdata);
        end
    end

    initial begin
        logic [63:0] wd;
        logic [63:0] a;
        int unsigned r;
        rst_n            = 1'b0;
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_size     = 2'd0;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = '0;
        bus.req_wdata    = '0;
        repeat (3) @(negedge clk);
        check("reset req_ready", 64'(bus.req_ready), 64'd1);
        check("reset rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("reset rsp_err", 64'(bus.rsp_err), 64'd0);
        check("reset rsp_rdata", bus.rsp_rdata, 64'd0);
        rst_n = 1'b1;

        // Give every word a known value so loads never touch uninitialised storage.
        for (int unsigned w = 0; w < DEPTH_WORDS; w++) begin
            issue(1'b1, 2'd3, 1'b0, 64'(w * 8), {$urandom, $urandom});
        end

        // Directed accesses, issued back-to-back with req_valid held high
        issue(1'b1, 2'd3, 1'b0, 64'h10, 64'h1122334455667788);
        issue(1'b0, 2'd3, 1'b0, 64'h10, '0, 1'b1, 64'h1122334455667788);
        issue(1'b0, 2'd0, 1'b0, 64'h10, '0, 1'b1, 64'hFFFFFFFFFFFFFF88);
        issue(1'b0, 2'd0, 1'b1, 64'h10, '0, 1'b1, 64'h0000000000000088);
        issue(1'b0, 2'd1, 1'b0, 64'h16, '0, 1'b1, 64'h0000000000001122);
        issue(1'b1, 2'd2, 1'b0, 64'h1E, 64'hFFFF0000DEADBEEF);
        issue(1'b0, 2'd2, 1'b0, 64'h1E, '0, 1'b1, 64'hFFFFFFFFDEADBEEF);
        issue(1'b0, 2'd1, 1'b1, 64'h1C, '0);
        issue(1'b0, 2'd3, 1'b0, 64'h20, '0);
        issue(1'b0, 2'd3, 1'b0, 64'h1000, '0, 1'b1, 64'h0);
        issue(1'b1, 2'd2, 1'b0, 64'hFFE, 64'h00000000CAFEF00D);
        issue(1'b0, 2'd1, 1'b1, 64'hFFE, '0);
        issue(1'b0, 2'd0, 1'b1, 64'h0000_0001_0000_0010, '0, 1'b1, 64'h0);
        idle();
        drain();

        // Reset during beat 2 of a split double store at 0x0C
        wd = 64'hA1A2A3A4B5B6B7B8;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_size  = 2'd3;
        bus.req_addr  = 64'h0C;
        bus.req_wdata = wd;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort req_ready", 64'(bus.req_ready), 64'd1);
        check("abort rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("abort rsp_rdata", bus.rsp_rdata, 64'd0);
        for (int unsigned i = 0; i < 4; i++) ref_mem[12 + i] = wd[8*i +: 8];
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        issue(1'b0, 2'd3, 1'b0, 64'h08, '0);
        issue(1'b0, 2'd2, 1'b1, 64'h10, '0);
        idle();
        drain();

        // Randomised traffic with boundary and far-out-of-range addresses mixed in
        for (int k = 0; k < 400; k++) begin
            r = $urandom_range(0, 9);
            if (r == 0)      a = 64'(MEM_BYTES - $urandom_range(0, 8));
            else if (r == 1) a = {$urandom, $urandom};
            else             a = 64'($urandom_range(0, MEM_BYTES - 1));
            issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  a, {$urandom, $urandom});
            if ($urandom_range(0, 2) == 0) begin
                idle();
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
        end
        idle();
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
